// File: rtl/aes128_key_sched_iter.sv
// Iterative AES-128 key expansion: one round key every two clocks.
// SUB cycle registers SubWord(RotWord(w3)); MIX cycle folds it into the key.
module aes128_key_sched_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         ready,
    output logic         key_valid,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SUB  = 2'd1;
    localparam logic [1:0] S_MIX  = 2'd2;

    localparam logic [3:0] NR_IDX = 4'(NR);

    // GF(2^8) multiply by x, reduced by the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) shift-and-add multiply
    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a6   = gf_mul(a3, a3);
        a12  = gf_mul(a6, a6);
        a15  = gf_mul(a12, a3);
        a30  = gf_mul(a15, a15);
        a60  = gf_mul(a30, a30);
        a120 = gf_mul(a60, a60);
        a240 = gf_mul(a120, a120);
        a252 = gf_mul(a240, a12);
        return gf_mul(a252, a2);
    endfunction

    // Forward S-box: inverse followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] a;
        a = gf_inv(x);
        return a
             ^ {a[6:0], a[7]}
             ^ {a[5:0], a[7:6]}
             ^ {a[4:0], a[7:5]}
             ^ {a[3:0], a[7:4]}
             ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]),
                sbox(w[15:8]),  sbox(w[7:0])};
    endfunction

    logic [1:0]   state_q, state_d;
    logic [127:0] key_q,   key_d;
    logic [3:0]   idx_q,   idx_d;
    logic [7:0]   rcon_q,  rcon_d;
    logic [31:0]  sub_q,   sub_d;
    logic         kv_q,    kv_d;
    logic         done_q,  done_d;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] n0, n1, n2, n3;
    logic [31:0] rot_w3;
    logic [3:0]  idx_inc;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    assign rot_w3  = {w3[23:0], w3[31:24]};
    assign idx_inc = idx_q + 4'd1;

    // Next round key from the registered S-box word
    always_comb begin
        n0 = w0 ^ sub_q ^ {rcon_q, 24'h000000};
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
    end

    assign ready     = (state_q == S_IDLE) && !done_q;
    assign key_valid = kv_q;
    assign done      = done_q;
    assign round_key = key_q;
    assign round_idx = idx_q;

    // Schedule sequencing: load, substitute, mix
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        sub_d   = sub_q;
        kv_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && ready) begin
                    key_d   = key_in;
                    idx_d   = 4'd0;
                    rcon_d  = 8'h01;
                    kv_d    = 1'b1;
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                sub_d   = sub_word(rot_w3);
                state_d = S_MIX;
            end
            S_MIX: begin
                key_d  = {n0, n1, n2, n3};
                idx_d  = idx_inc;
                rcon_d = xtime(rcon_q);
                kv_d   = 1'b1;
                if (idx_inc == NR_IDX) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SUB;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            rcon_q  <= 8'h01;
            sub_q   <= '0;
            kv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
            sub_q   <= sub_d;
            kv_q    <= kv_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_aes128_key_sched_iter.sv
// Bench for aes128_key_sched_iter: NR=10 and NR=1 instances
// checked against a word-level FIPS-197 key expansion model.
module tb_aes128_key_sched_iter;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         ready;
    logic         key_valid;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         done;

    logic         start1;
    logic [127:0] key_in1;
    logic         ready1;
    logic         key_valid1;
    logic [127:0] round_key1;
    logic [3:0]   round_idx1;
    logic         done1;

    int n_checks;
    int n_fail;
    int pulses;

    logic [7:0]   sb [256];
    logic [127:0] exp_rk [11];
    logic [127:0] obs_rk [11];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    aes128_key_sched_iter #(.NR(10)) dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in),
        .ready(ready), .key_valid(key_valid), .round_key(round_key),
        .round_idx(round_idx), .done(done)
    );

    aes128_key_sched_iter #(.NR(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .key_in(key_in1),
        .ready(ready1), .key_valid(key_valid1), .round_key(round_key1),
        .round_idx(round_idx1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // S-box table built by walking the multiplicative group with generator 3
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    // Textbook word-array key expansion
    task automatic compute_model(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic launch(input logic [127:0] key, input bit hold);
        @(negedge clk);
        start  = 1'b1;
        key_in = key;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Called #1 after the accepting edge; walks cycles t+1..t+22
    task automatic observe(input logic [127:0] key, input bit toggle);
        bit exp_kv;
        bit exp_done;
        bit exp_rdy;
        int r;
        compute_model(key);
        pulses = 0;
        for (int k = 1; k <= 22; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            if (toggle) key_in = {$urandom, $urandom, $urandom, $urandom};
            exp_kv   = (k % 2 == 1) && (k <= 21);
            exp_done = (k == 21);
            exp_rdy  = (k == 22);
            if (key_valid === 1'b1) pulses++;
            n_checks++;
            if (key_valid !== exp_kv) begin
                n_fail++;
                $display("FAIL key_valid k=%0d got=%b exp=%b", k, key_valid, exp_kv);
            end
            n_checks++;
            if (done !== exp_done) begin
                n_fail++;
                $display("FAIL done k=%0d got=%b exp=%b", k, done, exp_done);
            end
            n_checks++;
            if (ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL ready k=%0d got=%b exp=%b", k, ready, exp_rdy);
            end
            r = exp_kv ? (k - 1) / 2 : (k - 2) / 2;
            if (exp_kv) obs_rk[r] = round_key;
            n_checks++;
            if (round_key !== exp_rk[r]) begin
                n_fail++;
                $display("FAIL round_key k=%0d got=%h exp=%h", k, round_key, exp_rk[r]);
            end
            n_checks++;
            if (round_idx !== 4'(r)) begin
                n_fail++;
                $display("FAIL round_idx k=%0d got=%0d exp=%0d", k, round_idx, r);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        start1 = 1'b0;
        key_in = '0;
        key_in1 = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (ready !== 1'b1 || key_valid !== 1'b0 || done !== 1'b0 ||
            round_key !== 128'h0 || round_idx !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_state got rdy=%b kv=%b dn=%b key=%h idx=%0d exp 1,0,0,0,0",
                     ready, key_valid, done, round_key, round_idx);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fips();
        launch(FIPS_KEY, 1'b0);
        observe(FIPS_KEY, 1'b0);
        n_checks++;
        if (obs_rk[0] !== FIPS_KEY) begin
            n_fail++;
            $display("FAIL fips_r0 got=%h exp=%h", obs_rk[0], FIPS_KEY);
        end
        n_checks++;
        if (obs_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            n_fail++;
            $display("FAIL fips_r1 got=%h exp=a0fafe1788542cb123a339392a6c7605", obs_rk[1]);
        end
        n_checks++;
        if (obs_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            n_fail++;
            $display("FAIL fips_r10 got=%h exp=d014f9a8c9ee2589e13f0cc8b6630ca6", obs_rk[10]);
        end
    endtask

    task automatic test_zero_key();
        launch(128'h0, 1'b0);
        observe(128'h0, 1'b0);
        n_checks++;
        if (obs_rk[1] !== 128'h62636363626363636263636362636363) begin
            n_fail++;
            $display("FAIL zero_r1 got=%h exp=62636363626363636263636362636363", obs_rk[1]);
        end
        n_checks++;
        if (obs_rk[10] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
            n_fail++;
            $display("FAIL zero_r10 got=%h exp=b4ef5bcb3e92e21123e951cf6f8f188e", obs_rk[10]);
        end
        n_checks++;
        if (pulses !== 11) begin
            n_fail++;
            $display("FAIL zero_pulses got=%0d exp=11", pulses);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] ka, kb;
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        launch(ka, 1'b1);
        key_in = kb;
        observe(ka, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        observe(kb, 1'b0);
    endtask

    task automatic test_reset_mid();
        launch(FIPS_KEY, 1'b0);
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (ready !== 1'b1 || key_valid !== 1'b0 || done !== 1'b0 ||
            round_key !== 128'h0 || round_idx !== 4'h0) begin
            n_fail++;
            $display("FAIL mid_reset got rdy=%b kv=%b dn=%b key=%h idx=%0d exp 1,0,0,0,0",
                     ready, key_valid, done, round_key, round_idx);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (key_valid !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
                n_fail++;
                $display("FAIL post_reset_idle i=%0d got kv=%b dn=%b rdy=%b exp 0,0,1",
                         i, key_valid, done, ready);
            end
        end
        test_fips();
    endtask

    task automatic test_key_toggle();
        logic [127:0] k;
        for (int n = 0; n < 3; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            launch(k, 1'b0);
            observe(k, 1'b1);
        end
    endtask

    task automatic test_nr1();
        bit exp_kv;
        compute_model(FIPS_KEY);
        @(negedge clk);
        start1  = 1'b1;
        key_in1 = FIPS_KEY;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            exp_kv = (k == 1) || (k == 3);
            n_checks++;
            if (key_valid1 !== exp_kv || done1 !== (k == 3) || ready1 !== (k == 4)) begin
                n_fail++;
                $display("FAIL nr1_ctrl k=%0d got kv=%b dn=%b rdy=%b", k, key_valid1, done1, ready1);
            end
            if (k == 3) begin
                n_checks++;
                if (round_idx1 !== 4'd1 || round_key1 !== exp_rk[1]) begin
                    n_fail++;
                    $display("FAIL nr1_key got idx=%0d key=%h exp idx=1 key=%h",
                             round_idx1, round_key1, exp_rk[1]);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        build_sbox();
        test_reset();
        test_fips();
        test_zero_key();
        test_back_to_back();
        test_reset_mid();
        test_key_toggle();
        test_nr1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
